// File: rtl/banco_registros_pkg.sv
// Shared definitions for the Beta register file.
//   DATA_W    : register width in bits
//   ADDR_W    : address width; NUM_REGS = 2**ADDR_W
//   ZERO_REG  : index of the hardwired-zero register (R31)
// Optional feature macro: BANCO_REGISTROS_BYPASS_EN (write-through forwarding).
package banco_registros_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

endpackage

// File: rtl/banco_registros_read_port.sv
// One combinational read port of the register file.
//   rd_addr_i  : register index to read
//   regs_i     : flattened storage array from the top level
//   rst_i, wr_en_i, wr_addr_i, wr_data_i : write-port view, present only when
//                BANCO_REGISTROS_BYPASS_EN is defined (forwarding compare)
//   rd_data_o  : selected register contents, zero for ZERO_REG
module banco_registros_read_port
  import banco_registros_pkg::*;
(
  input  logic [ADDR_W-1:0]                rd_addr_i,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
`ifdef BANCO_REGISTROS_BYPASS_EN
  input  logic                             rst_i,
  input  logic                             wr_en_i,
  input  logic [ADDR_W-1:0]                wr_addr_i,
  input  logic [DATA_W-1:0]                wr_data_i,
`endif
  output logic [DATA_W-1:0]                rd_data_o
);

  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    if (rd_addr_i == ZERO_ADDR) begin
      rd_data_o = '0;
    end
`ifdef BANCO_REGISTROS_BYPASS_EN
    // Forward the pending write; reset wins because the write will be lost.
    if (!rst_i && wr_en_i && (wr_addr_i == rd_addr_i) && (rd_addr_i != ZERO_ADDR)) begin
      rd_data_o = wr_data_i;
    end
`endif
  end

endmodule

// File: rtl/banco_registros.sv
// 32 x 32-bit Beta register file: two combinational read ports, one clocked
// write port, R31 hardwired to zero.
//   CLK        : clock, all updates on the rising edge
//   RST        : synchronous active-high reset, clears every register
//   Add_A/B    : read addresses; Info_A/B : read data
//   Add_Dest, Write_Data, Write_En : write port
// Optional feature macro: BANCO_REGISTROS_BYPASS_EN enables write-through
// forwarding from Write_Data to the read ports.
module banco_registros
  import banco_registros_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] Add_A,
  input  logic [ADDR_W-1:0] Add_B,
  input  logic [ADDR_W-1:0] Add_Dest,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              Write_En,
  output logic [DATA_W-1:0] Info_A,
  output logic [DATA_W-1:0] Info_B
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    // Writes to the zero register are dropped so its flop stays at reset value.
    if (Write_En && (Add_Dest != ZERO_ADDR)) begin
      regs_d[Add_Dest] = Write_Data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // An unknown write address could scribble over arbitrary entries.
  always_ff @(posedge CLK) begin
    if (!RST && Write_En) begin
      assert (!$isunknown(Add_Dest));
    end
  end

  banco_registros_read_port u_port_a (
    .rd_addr_i (Add_A),
    .regs_i    (regs_q),
`ifdef BANCO_REGISTROS_BYPASS_EN
    .rst_i     (RST),
    .wr_en_i   (Write_En),
    .wr_addr_i (Add_Dest),
    .wr_data_i (Write_Data),
`endif
    .rd_data_o (Info_A)
  );

  banco_registros_read_port u_port_b (
    .rd_addr_i (Add_B),
    .regs_i    (regs_q),
`ifdef BANCO_REGISTROS_BYPASS_EN
    .rst_i     (RST),
    .wr_en_i   (Write_En),
    .wr_addr_i (Add_Dest),
    .wr_data_i (Write_Data),
`endif
    .rd_data_o (Info_B)
  );

endmodule

// File: tb/tb_banco_registros.sv
// Self-checking bench for banco_registros: directed sequences, a vector table
// and randomized traffic against an array-based reference model.
module tb_banco_registros;

`ifdef BANCO_REGISTROS_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic [4:0]  Add_A, Add_B, Add_Dest;
  logic [31:0] Write_Data;
  logic        Write_En;
  logic [31:0] Info_A, Info_B;

  banco_registros dut (
    .CLK        (CLK),
    .RST        (RST),
    .Add_A      (Add_A),
    .Add_B      (Add_B),
    .Add_Dest   (Add_Dest),
    .Write_Data (Write_Data),
    .Write_En   (Write_En),
    .Info_A     (Info_A),
    .Info_B     (Info_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;
  logic [31:0] model [32];

  typedef struct {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Reference: what a read port should show given the model and live inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd31) return 32'h0;
    if (Byp && !RST && Write_En && (Add_Dest == a)) return Write_Data;
    return model[a];
  endfunction

  // Clock edge plus model update, then settle 1 time unit past the edge.
  task automatic step();
    @(posedge CLK);
    if (RST) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (Write_En && (Add_Dest != 5'd31)) begin
      model[Add_Dest] = Write_Data;
    end
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[1] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd31, 32'h0,        32'h0};
    vecs[2] = '{1'b0, 5'd7,  32'hFFFFFFFF, 5'd7,  5'd7, 32'd35,        32'd35};
    vecs[3] = '{1'b1, 5'd4,  32'h00000011, 5'd4,  5'd3, 32'h11,        32'd15};
    vecs[4] = '{1'b1, 5'd4,  32'h00000022, 5'd4,  5'd0, 32'h22,        32'd0};
    vecs[5] = '{1'b1, 5'd0,  32'h0000CAFE, 5'd0,  5'd4, 32'hCAFE,      32'h22};

    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    RST = 1'b1; Write_En = 1'b0; Add_A = '0; Add_B = '0; Add_Dest = '0; Write_Data = '0;
    step(); step();
    RST = 1'b0;

    // Reset with a pending write: R3 written, then reset for 2 cycles while R5 write requested.
    Write_En = 1'b1; Add_Dest = 5'd3; Write_Data = 32'hDEADBEEF; Add_A = 5'd3;
    step();
    check("r3_written", Info_A, 32'hDEADBEEF);
    RST = 1'b1; Add_Dest = 5'd5; Write_Data = 32'h55555555;
    step(); step();
    RST = 1'b0; Write_En = 1'b0;
    #1;
    check("reset_r3", Info_A, 32'h0);
    for (int i = 0; i < 32; i++) begin
      Add_A = 5'(i); Add_B = 5'(31 - i);
      #1;
      check($sformatf("reset_a%0d", i), Info_A, 32'h0);
      check($sformatf("reset_b%0d", 31 - i), Info_B, 32'h0);
    end

    // Sequential write/readback.
    Write_En = 1'b1;
    for (int i = 0; i < 16; i++) begin
      Add_Dest = 5'(i); Write_Data = 32'(i * 5);
      step();
    end
    Write_En = 1'b0;
    for (int i = 0; i < 16; i++) begin
      Add_A = 5'(i); Add_B = 5'(15 - i);
      #1;
      check($sformatf("seq_a%0d", i), Info_A, 32'(i * 5));
      check($sformatf("seq_b%0d", 15 - i), Info_B, 32'((15 - i) * 5));
    end

    // Write disabled for 16 cycles.
    Write_En = 1'b0; Add_Dest = 5'd7; Write_Data = 32'hFFFFFFFF; Add_A = 5'd7;
    for (int i = 0; i < 16; i++) step();
    check("wr_disable_r7", Info_A, 32'd35);

    // Vector table: apply, clock, compare after the edge.
    foreach (vecs[k]) begin
      Write_En = vecs[k].we; Add_Dest = vecs[k].dest; Write_Data = vecs[k].data;
      Add_A = vecs[k].a; Add_B = vecs[k].b;
      step();
      check($sformatf("vec%0d_a", k), Info_A, vecs[k].exp_a);
      check($sformatf("vec%0d_b", k), Info_B, vecs[k].exp_b);
    end

    // Same-cycle read of the register being written.
    Write_En = 1'b1; Add_Dest = 5'd4; Write_Data = 32'h11; Add_A = 5'd4; Add_B = 5'd4;
    step();
    Write_Data = 32'h22;
    #1;
    check("bypass_pre_a", Info_A, Byp ? 32'h22 : 32'h11);
    check("bypass_pre_b", Info_B, Byp ? 32'h22 : 32'h11);
    step();
    check("bypass_post_a", Info_A, 32'h22);
    Add_Dest = 5'd31; Write_Data = 32'h77; Add_B = 5'd31;
    #1;
    check("bypass_zero_reg", Info_B, 32'h0);
    // Reset suppresses forwarding and drops the write.
    RST = 1'b1; Add_Dest = 5'd4; Write_Data = 32'h99;
    #1;
    check("bypass_rst_pre", Info_A, 32'h22);
    step();
    check("bypass_rst_post", Info_A, 32'h0);
    RST = 1'b0; Write_En = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      RST        = ($urandom_range(0, 39) == 0);
      Write_En   = $urandom_range(0, 3) != 0;
      Add_Dest   = 5'($urandom_range(0, 31));
      Write_Data = $urandom;
      Add_A      = ($urandom_range(0, 3) == 0) ? Add_Dest : 5'($urandom_range(0, 31));
      Add_B      = ($urandom_range(0, 3) == 0) ? Add_Dest : 5'($urandom_range(0, 31));
      #1;
      check($sformatf("rnd%0d_pre_a", n), Info_A, exp_rd(Add_A));
      check($sformatf("rnd%0d_pre_b", n), Info_B, exp_rd(Add_B));
      step();
      check($sformatf("rnd%0d_post_a", n), Info_A, exp_rd(Add_A));
      check($sformatf("rnd%0d_post_b", n), Info_B, exp_rd(Add_B));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
